// File: rtl/bus_master_mux_if.sv
// Upstream bus port shared by the channel multiplexer
// and whatever arbiter/slave sits above it.
interface bus_master_mux_if #(
  parameter int AW = 30,
  parameter int DW = 32
);
  logic          BusReq_;
  logic          BusGrnt_;
  logic [AW-1:0] BusAddr;
  logic          BusAs_;
  logic          BusRW;
  logic [DW-1:0] BusWrData;
  logic [DW-1:0] BusRdData;
  logic          BusRdy_;

  modport master (
    output BusReq_, BusAddr, BusAs_,
    output BusRW, BusWrData,
    input  BusGrnt_, BusRdData, BusRdy_
  );

  modport slave (
    input  BusReq_, BusAddr, BusAs_,
    input  BusRW, BusWrData,
    output BusGrnt_, BusRdData, BusRdy_
  );
endinterface

// File: rtl/bus_master_mux.sv
// Multiplexes NCH channel masters onto one upstream bus,
// with fixed-priority or round-robin arbitration and burst limit.
module bus_master_mux #(
  parameter int NCH       = 2,
  parameter int AW        = 30,
  parameter int DW        = 32,
  parameter int ARB_MODE  = 1,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH-1:0]    ChReq_,
  input  logic [NCH*AW-1:0] ChAddr,
  input  logic [NCH-1:0]    ChAs_,
  input  logic [NCH-1:0]    ChRW,
  input  logic [NCH*DW-1:0] ChWrData,
  output logic [NCH-1:0]    ChGrnt_,
  output logic [NCH-1:0]    ChRdy_,
  output logic [DW-1:0]     ChRdData,
  bus_master_mux_if.master  bus
);

  localparam int IW = $clog2(NCH);
  localparam int CW =
    (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CMAX = CW'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE, REQ, OWN
  } st_e;

  st_e           r_state;
  st_e           w_next;
  logic [IW-1:0] r_win;
  logic [IW-1:0] r_last;
  logic [IW-1:0] w_pick;
  logic [IW-1:0] w_idx;
  logic          w_found;
  logic [CW-1:0] r_cnt;
  logic [NCH-1:0] r_grnt_n;
  logic [NCH-1:0] w_win_oh;
  logic w_any;
  logic w_own;
  logic w_other;
  logic w_force;
  logic w_xfer;
  logic w_enter;

  function automatic logic [IW-1:0] arb_idx(
    input logic [IW-1:0] last,
    input int            k
  );
    int t;
    if (ARB_MODE != 0)
      t = (int'(last) + 1 + k) % NCH;
    else
      t = k;
    return IW'(t);
  endfunction

  always_comb begin
    w_pick  = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      w_idx = arb_idx(r_last, k);
      if (!w_found && !ChReq_[w_idx]) begin
        w_pick  = w_idx;
        w_found = 1'b1;
      end
    end
  end

  assign w_any    = ~&ChReq_;
  assign w_own    = (r_state == OWN);
  assign w_win_oh = NCH'(1) << r_win;
  assign w_other  = |(~ChReq_ & ~w_win_oh);
  // forced release waits for the winner's strobe to drop
  assign w_force  = (MAX_BURST != 0) &&
                    (r_cnt == CMAX) &&
                    w_other && ChAs_[r_win];
  assign w_xfer   = w_own && !ChAs_[r_win] &&
                    !bus.BusRdy_;
  assign w_enter  = (r_state == REQ) &&
                    (w_next == OWN);

  always_ff @(posedge clk) begin
    if (reset)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:
        if (w_any) w_next = REQ;
      REQ:
        if (ChReq_[r_win])       w_next = IDLE;
        else if (!bus.BusGrnt_)  w_next = OWN;
      OWN:
        if (ChReq_[r_win] || w_force)
          w_next = IDLE;
        else if (bus.BusGrnt_)
          w_next = REQ;
      default:
        w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_win    <= '0;
      r_last   <= IW'(NCH - 1);
      r_cnt    <= '0;
      r_grnt_n <= '1;
    end else begin
      r_grnt_n <= (w_next == OWN) ? ~w_win_oh : '1;
      if (r_state == IDLE && w_any)
        r_win <= w_pick;
      if (w_enter) begin
        r_last <= r_win;
        r_cnt  <= '0;
      end else if (w_xfer && r_cnt != CMAX) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign ChGrnt_ = r_grnt_n;

  always_comb begin
    bus.BusReq_   = (r_state == IDLE);
    bus.BusAs_    = 1'b1;
    bus.BusRW     = 1'b1;
    bus.BusAddr   = '0;
    bus.BusWrData = '0;
    ChRdy_        = '1;
    ChRdData      = bus.BusRdData;
    if (w_own) begin
      bus.BusAs_    = ChAs_[r_win];
      bus.BusRW     = ChRW[r_win];
      bus.BusAddr   = ChAddr[r_win*AW +: AW];
      bus.BusWrData = ChWrData[r_win*DW +: DW];
      ChRdy_[r_win] = bus.BusRdy_;
    end
  end

endmodule

// File: tb/tb_bus_master_mux.sv
// Random and directed checks of bus_master_mux (round-robin
// and fixed-priority instances) against a cycle reference model.
module tb_bus_master_mux;

  localparam int NCH  = 2;
  localparam int AW   = 30;
  localparam int DW   = 32;
  localparam int MAXB = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NCH-1:0]    ChReq_;
  logic [NCH*AW-1:0] ChAddr;
  logic [NCH-1:0]    ChAs_;
  logic [NCH-1:0]    ChRW;
  logic [NCH*DW-1:0] ChWrData;
  logic              BusGrnt_;
  logic              BusRdy_;
  logic [DW-1:0]     BusRdData;

  logic [NCH-1:0] g_rr, rdy_rr, g_fp, rdy_fp;
  logic [DW-1:0]  rd_rr, rd_fp;

  always #5 clk = ~clk;

  bus_master_mux_if #(.AW(AW), .DW(DW)) b_rr ();
  bus_master_mux_if #(.AW(AW), .DW(DW)) b_fp ();

  assign b_rr.BusGrnt_  = BusGrnt_;
  assign b_rr.BusRdy_   = BusRdy_;
  assign b_rr.BusRdData = BusRdData;
  assign b_fp.BusGrnt_  = BusGrnt_;
  assign b_fp.BusRdy_   = BusRdy_;
  assign b_fp.BusRdData = BusRdData;

  bus_master_mux #(
    .NCH(NCH), .AW(AW), .DW(DW),
    .ARB_MODE(1), .MAX_BURST(MAXB)
  ) u_rr (
    .clk(clk), .reset(reset),
    .ChReq_(ChReq_), .ChAddr(ChAddr),
    .ChAs_(ChAs_), .ChRW(ChRW),
    .ChWrData(ChWrData), .ChGrnt_(g_rr),
    .ChRdy_(rdy_rr), .ChRdData(rd_rr),
    .bus(b_rr)
  );

  bus_master_mux #(
    .NCH(NCH), .AW(AW), .DW(DW),
    .ARB_MODE(0), .MAX_BURST(MAXB)
  ) u_fp (
    .clk(clk), .reset(reset),
    .ChReq_(ChReq_), .ChAddr(ChAddr),
    .ChAs_(ChAs_), .ChRW(ChRW),
    .ChWrData(ChWrData), .ChGrnt_(g_fp),
    .ChRdy_(rdy_fp), .ChRdData(rd_fp),
    .bus(b_fp)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  // model index 0 = round-robin, 1 = fixed priority
  bit m_want[2];
  bit m_own[2];
  int m_win[2];
  int m_last[2];
  int m_cnt[2];

  function automatic int pick(input int m);
    int i;
    for (int k = 1; k <= NCH; k++) begin
      i = (m == 0) ? (m_last[m] + k) % NCH : k - 1;
      if (!ChReq_[i]) return i;
    end
    return 0;
  endfunction

  task automatic mdl_step();
    for (int m = 0; m < 2; m++) begin
      if (reset) begin
        m_want[m] = 0;
        m_own[m]  = 0;
        m_last[m] = NCH - 1;
        m_cnt[m]  = 0;
      end else if (!m_want[m]) begin
        if (ChReq_ != '1) begin
          m_win[m]  = pick(m);
          m_want[m] = 1;
        end
      end else if (!m_own[m]) begin
        if (ChReq_[m_win[m]])
          m_want[m] = 0;
        else if (!BusGrnt_) begin
          m_own[m]  = 1;
          m_last[m] = m_win[m];
          m_cnt[m]  = 0;
        end
      end else begin
        int w;
        bit others;
        bit xfer;
        w = m_win[m];
        others = 0;
        for (int j = 0; j < NCH; j++)
          if (j != w && !ChReq_[j]) others = 1;
        xfer = !ChAs_[w] && !BusRdy_;
        if (ChReq_[w] ||
            (m_cnt[m] == MAXB && MAXB != 0 &&
             others && ChAs_[w])) begin
          m_want[m] = 0;
          m_own[m]  = 0;
        end else if (BusGrnt_) begin
          m_own[m] = 0;
        end
        if (xfer && m_cnt[m] < MAXB) m_cnt[m]++;
      end
    end
  endtask

  task automatic chk_dut(
    input string p, input int m,
    input logic breq, input logic [1:0] gnt,
    input logic as_, input logic rw,
    input logic [AW-1:0] addr,
    input logic [DW-1:0] wd,
    input logic [1:0] rdy,
    input logic [DW-1:0] rdd
  );
    logic [1:0] eg, er;
    logic ea, ew;
    logic [AW-1:0] eaddr;
    logic [DW-1:0] ed;
    int w;
    w = m_win[m];
    eg = '1; er = '1; ea = 1; ew = 1;
    eaddr = '0; ed = '0;
    if (m_own[m]) begin
      eg[w] = 1'b0;
      ea    = ChAs_[w];
      ew    = ChRW[w];
      eaddr = ChAddr[w*AW +: AW];
      ed    = ChWrData[w*DW +: DW];
      er[w] = BusRdy_;
    end
    chk({p, "breq"}, 32'(breq), 32'(!m_want[m]));
    chk({p, "gnt"}, 32'(gnt), 32'(eg));
    chk({p, "as"}, 32'(as_), 32'(ea));
    chk({p, "rw"}, 32'(rw), 32'(ew));
    chk({p, "addr"}, 32'(addr), 32'(eaddr));
    chk({p, "wdata"}, wd, ed);
    chk({p, "rdy"}, 32'(rdy), 32'(er));
    chk({p, "rdata"}, rdd, BusRdData);
  endtask

  task automatic chk_all();
    chk_dut("rr_", 0, b_rr.BusReq_, g_rr,
            b_rr.BusAs_, b_rr.BusRW, b_rr.BusAddr,
            b_rr.BusWrData, rdy_rr, rd_rr);
    chk_dut("fp_", 1, b_fp.BusReq_, g_fp,
            b_fp.BusAs_, b_fp.BusRW, b_fp.BusAddr,
            b_fp.BusWrData, rdy_fp, rd_fp);
  endtask

  task automatic step();
    @(negedge clk);
    chk_all();
    @(posedge clk);
    mdl_step();
    #1;
  endtask

  int owners[$];
  int xfers[$];
  int nx, last_x, gap, fp0, fp1;
  logic [1:0] prev_g, prev_fp;
  bit tog, found;

  initial begin
    reset     = 1'b1;
    ChReq_    = '1;
    ChAs_     = '1;
    ChRW      = '1;
    ChAddr    = '0;
    ChWrData  = '0;
    BusGrnt_  = 1'b1;
    BusRdy_   = 1'b1;
    BusRdData = '0;
    @(posedge clk);
    mdl_step();
    #1;
    repeat (2) step();
    chk("rst_breq", 32'(b_rr.BusReq_), 32'd1);
    chk("rst_gnt", 32'(g_rr), 32'h3);

    // two-cycle grant latency, then a ch0 write
    reset    = 1'b0;
    BusGrnt_ = 1'b0;
    ChReq_   = 2'b10;
    step();
    chk("lat_breq", 32'(b_rr.BusReq_), 32'd0);
    step();
    chk("lat_gnt", 32'(g_rr), 32'h2);
    ChAs_    = 2'b10;
    ChRW     = 2'b10;
    ChAddr   = {30'h0, 30'h100};
    ChWrData = {32'h0, 32'hDEADBEEF};
    #1;
    chk("wr_data", b_rr.BusWrData, 32'hDEADBEEF);
    chk("wr_addr", 32'(b_rr.BusAddr), 32'h100);
    chk("wr_rw", 32'(b_rr.BusRW), 32'd0);
    step();

    // reset in the middle of an unfinished transfer
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("rmid_as", 32'(b_rr.BusAs_), 32'd1);
    chk("rmid_breq", 32'(b_rr.BusReq_), 32'd1);
    chk("rmid_gnt", 32'(g_rr), 32'h3);
    ChAs_  = '1;
    ChReq_ = '1;
    step();

    // upstream preemption during ch1 ownership
    ChReq_ = 2'b01;
    step();
    step();
    chk("pre_own", 32'(g_rr), 32'h1);
    BusGrnt_ = 1'b1;
    step();
    chk("pre_gnt", 32'(g_rr), 32'h3);
    chk("pre_breq", 32'(b_rr.BusReq_), 32'd0);
    step();
    step();
    chk("pre_hold", 32'(g_rr), 32'h3);
    BusGrnt_ = 1'b0;
    step();
    chk("pre_regnt", 32'(g_rr), 32'h1);
    ChReq_ = '1;
    step();
    step();

    // both channels request with alternating read strobes
    reset = 1'b1;
    step();
    reset   = 1'b0;
    ChReq_  = 2'b00;
    BusRdy_ = 1'b0;
    ChRW    = 2'b11;
    prev_g  = 2'b11;
    prev_fp = 2'b11;
    tog = 0; nx = 0; last_x = -100;
    gap = -1; fp0 = 0; fp1 = 0;
    for (int k = 0; k < 70; k++) begin
      ChAs_ = tog ? 2'b00 : 2'b11;
      tog = !tog;
      #1;
      if (g_rr != 2'b11) begin
        if (prev_g == 2'b11) begin
          owners.push_back(g_rr == 2'b10 ? 0 : 1);
          if (owners.size() == 2) gap = k - 1 - last_x;
        end
        if (b_rr.BusAs_ == 1'b0) begin
          nx++;
          last_x = k;
        end
      end else if (prev_g != 2'b11) begin
        xfers.push_back(nx);
        nx = 0;
      end
      prev_g = g_rr;
      if (g_fp == 2'b01) fp1++;
      if (g_fp == 2'b10 && prev_fp == 2'b11) fp0++;
      prev_fp = g_fp;
      step();
    end
    chk("rr_ngrants", 32'(owners.size() >= 4), 32'd1);
    foreach (owners[i])
      chk("rr_owner", 32'(owners[i]), 32'(i % 2));
    foreach (xfers[i])
      chk("burst_len", 32'(xfers[i]), 32'd4);
    chk("rel_gap", 32'(gap), 32'd3);
    chk("fp_starve", 32'(fp1), 32'd0);
    chk("fp_ch0", 32'(fp0 >= 2), 32'd1);

    // ch0 withdraws; fixed priority must now serve ch1
    ChReq_ = 2'b01;
    ChAs_  = '1;
    found  = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (g_fp == 2'b01) found = 1;
    end
    chk("fp_ch1", 32'(found), 32'd1);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(0, 7) == 0)
          ChReq_[c] = !ChReq_[c];
      ChAs_     = 2'($urandom);
      ChRW      = 2'($urandom);
      ChAddr    = 60'({$urandom, $urandom});
      ChWrData  = {$urandom, $urandom};
      BusGrnt_  = ($urandom_range(0, 7) == 0);
      BusRdy_   = 1'($urandom);
      BusRdData = $urandom;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bus_master_mux.md
BUS_MASTER_MUX -- requirements
Module: bus_master_mux

Interface
REQ-001 SHALL have parameter NCH, default 2: number of master channels; legal range 2..8.
REQ-002 SHALL have parameter AW, default 30: word address width.
REQ-003 SHALL have parameter DW, default 32: data width.
REQ-004 SHALL have parameter ARB_MODE, default 1: 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-005 SHALL have parameter MAX_BURST, default 4: transfers allowed before forced release when another channel waits; 0 disables the limit.
REQ-006 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port ChReq_  input  NCH  per-channel bus request, active low.
REQ-009 SHALL have port ChAddr  input  NCH*AW  per-channel address, channel i in bits [i*AW +: AW].
REQ-010 SHALL have port ChAs_  input  NCH  per-channel address strobe, active low.
REQ-011 SHALL have port ChRW  input  NCH  per-channel direction; 1 = read, 0 = write.
REQ-012 SHALL have port ChWrData  input  NCH*DW  per-channel write data.
REQ-013 SHALL have port ChGrnt_  output  NCH  per-channel grant, active low, registered.
REQ-014 SHALL have port ChRdy_  output  NCH  per-channel ready, active low.
REQ-015 SHALL have port ChRdData  output  DW  read data, shared by all channels.
REQ-016 SHALL have ports BusReq_ output 1, BusGrnt_ input 1, BusAddr output AW, BusAs_ output 1, BusRW output 1, BusWrData output DW, BusRdData input DW, BusRdy_ input 1: upstream master port.

Function
REQ-017 SHALL implement FSM states IDLE, REQ, OWN.
REQ-018 IDLE: when any ChReq_ bit is low, SHALL latch the winner per ARB_MODE, drive BusReq_=0 and enter REQ the next cycle.
REQ-019 Round-robin SHALL search from index last+1 with wrap to 0; last SHALL update to the winner on entry to OWN.
REQ-020 REQ: on BusGrnt_=0, SHALL enter OWN and drive ChGrnt_[winner]=0 from the next cycle.
REQ-021 REQ: if ChReq_[winner] rises before the grant, SHALL return to IDLE with BusReq_=1.
REQ-022 OWN: SHALL pass through the winner's ChAddr, ChAs_, ChRW and ChWrData to the Bus* outputs combinationally.
REQ-023 OWN: SHALL route BusRdy_ to ChRdy_[winner] only; all other ChRdy_ bits SHALL be 1.
REQ-024 ChRdData SHALL equal BusRdData in all states.
REQ-025 Outside OWN: BusAs_=1, BusRW=1, BusAddr=0, BusWrData=0, and all ChRdy_=1.
REQ-026 Transfer count SHALL increment when BusAs_=0 and BusRdy_=0 in the same cycle, saturating at MAX_BURST, and SHALL clear on entry to OWN.
REQ-027 OWN exits to IDLE (BusReq_=1, ChGrnt_ all 1 next cycle) when any of the following holds:
- ChReq_[winner]=1;
- count=MAX_BURST (MAX_BURST≠0), another ChReq_ bit is low, and ChAs_[winner]=1.
REQ-028 A forced release SHALL NOT occur while ChAs_[winner]=0; the in-flight transfer completes first.
REQ-029 OWN: if BusGrnt_ rises (upstream preemption), SHALL deassert ChGrnt_[winner], keep BusReq_=0, hold the winner and enter REQ.
REQ-030 At most one ChGrnt_ bit SHALL be low at any time.
REQ-031 Minimum latency SHALL be 2 cycles from ChReq_ low to ChGrnt_ low, given BusGrnt_=0 one cycle after BusReq_=0.

Reset
REQ-032 With reset high, the following SHALL hold at the next edge:
- state=IDLE, BusReq_=1, ChGrnt_ all 1;
- count=0, last=NCH-1, so channel 0 wins first in round-robin mode.
REQ-033 Reset asserted mid-transfer SHALL abandon the transfer with no further Bus* activity; combinational outputs SHALL take their non-OWN values.

Verification
REQ-034 NCH=2, ARB_MODE=1: ChReq_=2'b00 held, BusGrnt_=0 -> grants alternate ch0, ch1, ch0 on successive IDLE entries.
REQ-035 ARB_MODE=0, ChReq_=2'b00 -> ch0 granted on every arbitration; ch1 starves until ChReq_[0]=1.
REQ-036 MAX_BURST=4, ch0 issues 6 back-to-back reads with BusRdy_=0, ch1 requesting -> ch0 released after its 4th transfer; ch1 granted 3 cycles later.
REQ-037 BusGrnt_ raised for 3 cycles during ch1 OWN -> ChGrnt_[1]=1 within 1 cycle; BusReq_ stays 0; ch1 regranted after BusGrnt_ returns to 0.
REQ-038 Reset pulsed while BusAs_=0 and BusRdy_=1 -> next cycle BusAs_=1, BusReq_=1, ChGrnt_=2'b11.
REQ-039 ch0 write with ChWrData[31:0]=32'hDEADBEEF, ChAddr=30'h100 during OWN -> BusWrData=32'hDEADBEEF, BusAddr=30'h100, BusRW=0 in the same cycle.
